serial_add_arb: RTL and testbench
=================================

# serial_add_arb

Round-robin arbiter and sequencer that shares one serial 8-bit adder among `NREQ` requesters.

- Each requester presents an operand pair with a valid/ready handshake.
- The arbiter grants one requester at a time and launches the adder with a start pulse.
- It waits for the adder's done pulse, then returns sum and carry-out to the granted requester only.

It sits between client logic and the single `add_serial` datapath instance.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand width; must match the adder
- `TIMEOUT`, 20, max cycles to wait for `add_done` (used only with `SERIAL_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  one-hot grant/accept
- `req_a`  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  operand B, same packing as `req_a`
- `rsp_valid`  out  NREQ  one-hot, 1-cycle result strobe
- `rsp_sum`  out  WIDTH  result sum
- `rsp_cout`  out  1  result carry-out
- `rsp_err`  out  1  timeout flag; constant 0 without the macro
- `add_start`  out  1  1-cycle launch pulse to the adder
- `add_a`, `add_b`  out  WIDTH  adder operands
- `add_done`  in  1  1-cycle adder completion pulse
- `add_sum`  in  WIDTH  adder sum, valid in the `add_done` cycle
- `add_cout`  in  1  adder carry-out, valid in the `add_done` cycle

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- **IDLE:**
  - Round-robin selects grant g: the first asserted `req_valid` after pointer `last`, searching upward with wrap.
  - `req_ready[g]`=1 combinationally, only in IDLE, only when some `req_valid` is set.
  - On handshake, latch `req_a[g]`, `req_b[g]` and g, then go to START.
- **START:** `add_start`=1 for exactly one cycle; go to WAIT.
- **WAIT:** on `add_done`, latch `add_sum`/`add_cout` and go to RESP.
- **RESP:**
  - `rsp_valid[g]`=1 for one cycle, with `rsp_sum`/`rsp_cout` held from the latch.
  - Set `last`=g; go to IDLE.
- `add_a`/`add_b` are driven from the latched registers and stay stable from START until the next grant.
- `add_done` outside WAIT is ignored.
- Requesters hold `req_valid` and operands until ready. The arbiter never drops a pending request, and never grants while not in IDLE.
- Fairness: with all requesters active, grant order is 0,1,…,NREQ-1,0,…
- No arithmetic in this block; `WIDTH` bits plus carry pass through.

## Timing
- Reset values:
  - state IDLE; `last`=NREQ-1, so requester 0 has first priority.
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_err`=0, `add_start`=0, `add_a`=0, `add_b`=0.
- Accept at cycle T:
  - `add_start` at T+1.
  - `add_done` at T+1+L, where L≥1 is the adder latency (L=9 for the 8-bit serial adder).
  - `rsp_valid` at T+2+L.
  - Next grant possible at T+3+L.
- Simultaneous requests: exactly one is granted per op; the others wait in IDLE order.
- A new `req_valid` arriving in the RESP cycle is eligible in the following IDLE cycle.
- Reset mid-operation (any state):
  - Immediately return to IDLE with reset values; no `rsp_valid` for the aborted op.
  - The adder is reset on the same `rst`.

## Configuration
- `SERIAL_ARB_TIMEOUT_EN` defined:
  - A cycle counter clears in START and increments in WAIT.
  - When it reaches `TIMEOUT` without `add_done`, go to RESP with `rsp_err`=1, `rsp_sum`=0 and `rsp_cout`=0.
  - `add_done` in the same cycle as the timeout wins, giving a normal result with `rsp_err`=0.
- Not defined: no counter; WAIT holds indefinitely; `rsp_err` tied 0.

## Structure
- Shared package `serial_add_pkg`:
  - state enum (IDLE/START/WAIT/RESP, 2 bits)
  - default `WIDTH`/`NREQ` constants
  - timeout default
- Sub-module `rr_arbiter`:
  - Combinational round-robin selector.
  - Inputs: request vector and `last` pointer. Outputs: one-hot grant and grant index.
- The FSM, latches and counter stay in the top level.

## Test plan
- Single requester 1 sends a=8'h3C, b=8'h5A with adder L=9:
  - `add_start` occurs 1 cycle after accept.
  - `rsp_valid`=4'b0010 with sum=8'h96, cout=0 at accept+11.
- Requesters 0 and 2 assert in the same cycle after reset: 0 is served first, then 2; `req_ready` is never multi-hot.
- All four held valid for 8 ops: grant order 0,1,2,3,0,1,2,3.
- Requester 3 sends a=8'hFF, b=8'h01: sum=8'h00, cout=1, delivered only on `rsp_valid[3]`.
- `rst` pulsed in WAIT: outputs return to reset values and no `rsp_valid` follows. The next request completes normally with requester 0 at priority.
- With `SERIAL_ARB_TIMEOUT_EN` and the adder stubbed to never assert `add_done`: `rsp_err`=1, sum=0 exactly `TIMEOUT`+1 cycles after `add_start`. The next request is served.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial-adder arbiter: sequencer state encoding,
// default sizing constants and an index-width helper.
package serial_add_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: grants the first request strictly above
// the last-served index, wrapping to the lowest request when none is above it.
module rr_arbiter
  import serial_add_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any
);

  logic [NREQ-1:0] above_mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] pick_src;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign above_mask[gi] = (IDXW'(gi) > last);
    end
  endgenerate

  assign masked   = req & above_mask;
  assign pick_src = (|masked) ? masked : req;
  // Isolate the lowest set bit of the chosen request set.
  assign grant    = pick_src & (~pick_src + NREQ'(1));
  assign any      = |req;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = grant_idx | IDXW'(i);
    end
  end

endmodule

// File: rtl/serial_add_arb.sv
// Round-robin sequencer sharing one serial adder among NREQ requesters.
// Optional add_done watchdog enabled by defining SERIAL_ARB_TIMEOUT_EN.
module serial_add_arb
  import serial_add_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_err,
  output logic                  add_start,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic                  add_done,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout
);

  localparam int IDXW = idx_width(NREQ);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NREQ - 1);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("serial_add_arb: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  arb_state_t       state_reg, state_next;
  logic [IDXW-1:0]  last_reg, last_next;
  logic [IDXW-1:0]  gidx_reg, gidx_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             timed_out;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic [NREQ-1:0]  rr_grant;
  logic [IDXW-1:0]  rr_idx;
  logic             rr_any;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi]      = req_a[gi*WIDTH +: WIDTH];
      assign op_b[gi]      = req_b[gi*WIDTH +: WIDTH];
      assign rsp_valid[gi] = (state_reg == RESP) && (gidx_reg == IDXW'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req       (req_valid),
    .last      (last_reg),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

`ifdef SERIAL_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);

  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            err_reg, err_next;

  // Fires on the WAIT cycle whose increment would make the count reach TIMEOUT.
  assign timed_out = (state_reg == WAIT) && !add_done && (cnt_reg == CNTW'(TIMEOUT - 1));
  assign rsp_err   = err_reg;

  always_comb begin
    cnt_next = cnt_reg;
    err_next = err_reg;
    if (state_reg == START) begin
      cnt_next = '0;
    end else if (state_reg == WAIT) begin
      cnt_next = cnt_reg + CNTW'(1);
      if (add_done)       err_next = 1'b0;
      else if (timed_out) err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    gidx_next  = gidx_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    case (state_reg)
      IDLE: begin
        if (rr_any) begin
          gidx_next  = rr_idx;
          a_next     = op_a[rr_idx];
          b_next     = op_b[rr_idx];
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        // A done pulse coinciding with the watchdog still yields a real result.
        if (add_done) begin
          sum_next   = add_sum;
          cout_next  = add_cout;
          state_next = RESP;
        end else if (timed_out) begin
          sum_next   = '0;
          cout_next  = 1'b0;
          state_next = RESP;
        end
      end
      RESP: begin
        last_next  = gidx_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= LAST_RST;
      gidx_reg  <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      gidx_reg  <= gidx_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
    end
  end

  assign req_ready = (state_reg == IDLE) ? rr_grant : '0;
  assign add_start = (state_reg == START);
  assign add_a     = a_reg;
  assign add_b     = b_reg;
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = cout_reg;

endmodule

// File: tb/tb_serial_add_arb.sv
// Bench for serial_add_arb: behavioural adder stub, per-requester operand
// queues, a cycle-level expectation model and directed scenarios.
module tb_serial_add_arb;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 20;
  localparam int LAT     = 9;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout, rsp_err;
  logic                  add_start;
  logic [WIDTH-1:0]      add_a, add_b;
  logic                  add_done;
  logic [WIDTH-1:0]      add_sum;
  logic                  add_cout;

  always #5 clk = ~clk;

  serial_add_arb #(
    .NREQ    (NREQ),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_done  (add_done),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // ---------------- adder stub: done LAT cycles after start ----------------
  bit               never_done = 1'b0;
  bit               spur_done  = 1'b0;
  logic             stub_busy, stub_done, stub_cout;
  logic [WIDTH-1:0] stub_sum, sa, sb;
  int               stub_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0; stub_cnt <= 0; stub_done <= 1'b0;
      stub_sum  <= '0;   stub_cout <= 1'b0; sa <= '0; sb <= '0;
    end else begin
      stub_done <= 1'b0;
      if (add_start) begin
        stub_busy <= 1'b1; stub_cnt <= 1; sa <= add_a; sb <= add_b;
      end else if (stub_busy) begin
        if (stub_cnt == LAT - 1) begin
          stub_busy <= 1'b0;
          if (!never_done) begin
            stub_done <= 1'b1;
            {stub_cout, stub_sum} <= {1'b0, sa} + {1'b0, sb};
          end
        end
        stub_cnt <= stub_cnt + 1;
      end
    end
  end

  assign add_done = stub_done | spur_done;
  assign add_sum  = spur_done ? 8'hEE : stub_sum;
  assign add_cout = spur_done ? 1'b0 : stub_cout;

  // ---------------- requester queues and driver ----------------
  logic [15:0]     ops [NREQ][16];
  int              head [NREQ] = '{default: 0};
  int              tail [NREQ] = '{default: 0};
  logic [NREQ-1:0] acc_mask = '0;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) head[i] = head[i] + 1;
      if (!rst && head[i] < tail[i]) begin
        req_valid[i]             = 1'b1;
        req_a[i*WIDTH +: WIDTH]  = ops[i][head[i]][15:8];
        req_b[i*WIDTH +: WIDTH]  = ops[i][head[i]][7:0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  task automatic push(input int i, input logic [7:0] a, input logic [7:0] b);
    ops[i][tail[i]] = {a, b};
    tail[i] = tail[i] + 1;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first asserted request after 'last', searching upward with wrap.
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    int j;
    for (int k = 1; k <= NREQ; k++) begin
      j = (last + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // model state
  bit               m_busy = 1'b0;
  int               m_last = NREQ - 1;
  int               m_idx = 0, m_acc = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_add_a = '0, m_add_b = '0, m_sum = '0;
  logic             m_cout = 1'b0, m_err = 1'b0;

  // logs of observed DUT events for the directed checks
  logic [NREQ-1:0]  lg_mask [64];
  logic [WIDTH-1:0] lg_sum [64];
  logic             lg_cout [64], lg_err [64];
  int               lg_cyc [64];
  int               n_lg = 0;
  int               gr_idx [64], gr_cyc [64];
  int               n_gr = 0;
  int               last_start = 0, start_cnt = 0, multi_hot = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ready, e_rsp, hs;
    logic            e_start;
    int              pick, resp_at;
    e_ready = '0; e_rsp = '0; e_start = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_last = NREQ - 1; m_add_a = '0; m_add_b = '0;
      m_sum = '0; m_cout = 1'b0; m_err = 1'b0;
    end else begin
      if (!m_busy && req_valid != '0) begin
        pick = rr_pick(req_valid, m_last);
        e_ready[pick] = 1'b1;
      end
      e_start = m_busy && (cyc == m_acc + 1);
      resp_at = m_acc + 2 + (never_done ? TIMEOUT : LAT);
      if (m_busy && cyc == resp_at) begin
        e_rsp[m_idx] = 1'b1;
        if (never_done) begin
          m_sum = '0; m_cout = 1'b0; m_err = 1'b1;
        end else begin
          {m_cout, m_sum} = {1'b0, m_a} + {1'b0, m_b};
          m_err = 1'b0;
        end
      end
    end
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("add_start", add_start, e_start);
    chk("add_a", add_a, m_add_a);
    chk("add_b", add_b, m_add_b);
    chk("rsp_sum", rsp_sum, m_sum);
    chk("rsp_cout", rsp_cout, m_cout);
    chk("rsp_err", rsp_err, m_err);

    if ($countones(req_ready) > 1) multi_hot++;
    hs = rst ? '0 : (req_ready & req_valid);
    acc_mask = hs;
    if (hs != '0 && n_gr < 64) begin
      for (int i = 0; i < NREQ; i++) if (hs[i]) gr_idx[n_gr] = i;
      gr_cyc[n_gr] = cyc;
      n_gr++;
    end
    if (add_start && !rst) begin
      last_start = cyc;
      start_cnt++;
    end
    if (rsp_valid != '0 && n_lg < 64) begin
      lg_mask[n_lg] = rsp_valid; lg_sum[n_lg] = rsp_sum;
      lg_cout[n_lg] = rsp_cout;  lg_err[n_lg] = rsp_err; lg_cyc[n_lg] = cyc;
      $display("rsp mask=%b sum=%h cout=%b err=%b cycle=%0d", rsp_valid, rsp_sum, rsp_cout, rsp_err, cyc);
      n_lg++;
    end

    if (!rst) begin
      if (e_rsp != '0) begin
        m_busy = 1'b0;
        m_last = m_idx;
      end
      if ((e_ready & req_valid) != '0) begin
        m_busy  = 1'b1;
        m_idx   = rr_pick(req_valid, m_last);
        m_a     = req_a[m_idx*WIDTH +: WIDTH];
        m_b     = req_b[m_idx*WIDTH +: WIDTH];
        m_acc   = cyc;
        m_add_a = m_a;
        m_add_b = m_b;
      end
    end
  end

  // ---------------- scenario helpers ----------------
  task automatic wait_idle(input string nm);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); #3;
      done = !m_busy && queues_empty();
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s: still busy after 400 cycles, required idle", nm);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int b_lg, b_gr, s0;
    bit seen;

    // reset state
    @(negedge clk);
    chk("rst_add_start", add_start, 1'b0);
    chk("rst_rsp_sum", rsp_sum, 8'h00);
    chk("rst_req_ready", req_ready, 4'b0000);
    @(posedge clk); #2 rst = 1'b0;

    // single requester 1: 3C + 5A
    b_lg = n_lg; b_gr = n_gr;
    push(1, 8'h3C, 8'h5A);
    wait_idle("t1_done");
    chk("t1_grant", gr_idx[b_gr], 1);
    chk("t1_mask", lg_mask[b_lg], 4'b0010);
    chk("t1_sum", lg_sum[b_lg], 8'h96);
    chk("t1_cout", lg_cout[b_lg], 1'b0);
    chk("t1_start_lat", last_start - gr_cyc[b_gr], 1);
    chk("t1_rsp_lat", lg_cyc[b_lg] - gr_cyc[b_gr], 11);

    // requesters 0 and 2 together right after reset
    do_reset();
    b_lg = n_lg; b_gr = n_gr; multi_hot = 0;
    push(0, 8'h10, 8'h20);
    push(2, 8'h30, 8'h40);
    wait_idle("t2_done");
    chk("t2_first", gr_idx[b_gr], 0);
    chk("t2_second", gr_idx[b_gr+1], 2);
    chk("t2_sum0", lg_sum[b_lg], 8'h30);
    chk("t2_sum2", lg_sum[b_lg+1], 8'h70);
    chk("t2_onehot", multi_hot, 0);

    // all four held valid for eight operations
    do_reset();
    b_gr = n_gr;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) push(i, 8'(i * 16 + k), 8'(k + 1));
    wait_idle("t3_done");
    for (int j = 0; j < 8; j++) chk($sformatf("t3_order%0d", j), gr_idx[b_gr+j], j % 4);

    // requester 3: FF + 01 carries out
    b_lg = n_lg;
    push(3, 8'hFF, 8'h01);
    wait_idle("t4_done");
    chk("t4_mask", lg_mask[b_lg], 4'b1000);
    chk("t4_sum", lg_sum[b_lg], 8'h00);
    chk("t4_cout", lg_cout[b_lg], 1'b1);

    // stray add_done while idle must be ignored
    @(posedge clk); #2 spur_done = 1'b1;
    @(posedge clk); #2 spur_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_sum_held", rsp_sum, 8'h00);
    chk("t5_cout_held", rsp_cout, 1'b1);
    chk("t5_no_rsp", rsp_valid, 4'b0000);

    // reset while waiting on the adder
    s0 = start_cnt; seen = 1'b0;
    push(2, 8'h11, 8'h22);
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #3;
      seen = (start_cnt != s0);
    end
    chk("t6_started", seen, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_add_a", add_a, 8'h00);
    chk("t6_rst_add_b", add_b, 8'h00);
    chk("t6_rst_sum", rsp_sum, 8'h00);
    @(posedge clk); #2 rst = 1'b0;
    b_lg = n_lg;
    push(3, 8'h05, 8'h06);
    push(0, 8'h07, 8'h08);
    wait_idle("t6_done");
    chk("t6_count", n_lg - b_lg, 2);
    chk("t6_first_mask", lg_mask[b_lg], 4'b0001);
    chk("t6_first_sum", lg_sum[b_lg], 8'h0F);
    chk("t6_second_mask", lg_mask[b_lg+1], 4'b1000);
    chk("t6_second_sum", lg_sum[b_lg+1], 8'h0B);

`ifdef SERIAL_ARB_TIMEOUT_EN
    // adder never answers: watchdog responds with an error
    never_done = 1'b1;
    b_lg = n_lg;
    push(1, 8'h12, 8'h34);
    wait_idle("t7_done");
    chk("t7_mask", lg_mask[b_lg], 4'b0010);
    chk("t7_err", lg_err[b_lg], 1'b1);
    chk("t7_sum", lg_sum[b_lg], 8'h00);
    chk("t7_lat", lg_cyc[b_lg] - last_start, TIMEOUT + 1);
    never_done = 1'b0;
    b_lg = n_lg;
    push(2, 8'h21, 8'h43);
    wait_idle("t7_next");
    chk("t7_next_err", lg_err[b_lg], 1'b0);
    chk("t7_next_sum", lg_sum[b_lg], 8'h64);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
